// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RISC-V I/S/B immediate extraction with registered 64-bit sign-extended output
module imm_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [1:0]  ImmSrc,
    output logic [63:0] Out
);

    localparam logic [1:0] IMM_I    = 2'b00;
    localparam logic [1:0] IMM_S    = 2'b01;
    localparam logic [1:0] IMM_B    = 2'b10;

    // instr[31] is the sign bit for every format, so the fill is shared
    logic        sign_bit;
    logic [11:0] i_field;
    logic [11:0] s_field;
    logic [12:0] b_field;
    logic [63:0] out_d;
    logic [63:0] out_q;

    assign sign_bit = instr[31];
    assign i_field  = instr[31:20];
    assign s_field  = {instr[31:25], instr[11:7]};
    assign b_field  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    // Select the field for the requested format; unused or unknown codes give zero
    always_comb begin
        out_d = 64'h0;
        case (ImmSrc)
            IMM_I:   out_d = {{52{sign_bit}}, i_field};
            IMM_S:   out_d = {{52{sign_bit}}, s_field};
            IMM_B:   out_d = {{51{sign_bit}}, b_field};
            default: out_d = 64'h0;
        endcase
    end

    // Output register: loads every edge, cleared immediately by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= 64'h0;
        end else begin
            out_q <= out_d;
        end
    end

    assign Out = out_q;

endmodule

// File: tb/tb_imm_gen.sv
// tb/tb_imm_gen.sv - self-checking bench for imm_gen with randomized stimulus and arithmetic reference model
module tb_imm_gen;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [1:0]  ImmSrc;
    logic [63:0] Out;

    int checks;
    int errors;

    imm_gen dut (
        .clk    (clk),
        .reset  (reset),
        .instr  (instr),
        .ImmSrc (ImmSrc),
        .Out    (Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: weighted sum of the immediate's bits, sign bit carrying negative weight
    function automatic logic [63:0] model(input logic [31:0] ins, input logic [1:0] src);
        longint v;
        v = 0;
        case (src)
            2'd0: begin
                v = longint'(ins[30:20]);
                if (ins[31]) v = v - 2048;
            end
            2'd1: begin
                v = longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
                if (ins[31]) v = v - 2048;
            end
            2'd2: begin
                v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (ins[31]) v = v - 4096;
            end
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    task automatic test_reset;
        // load something nonzero first so the asynchronous clear is observable
        @(negedge clk);
        reset  = 1'b0;
        instr  = 32'h12345678;
        ImmSrc = 2'b00;
        @(negedge clk);
        checks++;
        if (Out !== 64'h0000000000000123) begin
            errors++;
            $display("FAIL preload: got %h expected %h", Out, 64'h0000000000000123);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (Out !== 64'h0) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", Out, 64'h0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (Out !== 64'h0) begin
                errors++;
                $display("FAIL reset_hold: got %h expected %h", Out, 64'h0);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] ins [6];
        logic [1:0]  src [6];
        logic [63:0] req [6];
        ins[0] = 32'h12345678; src[0] = 2'b00; req[0] = 64'h0000000000000123;
        ins[1] = 32'hFFF00093; src[1] = 2'b00; req[1] = 64'hFFFFFFFFFFFFFFFF;
        ins[2] = 32'h87654321; src[2] = 2'b01; req[2] = 64'hFFFFFFFFFFFFF866;
        ins[3] = 32'hABCDEF01; src[3] = 2'b10; req[3] = 64'hFFFFFFFFFFFFF2BE;
        ins[4] = 32'h00000000; src[4] = 2'b11; req[4] = 64'h0;
        ins[5] = 32'hFFFFFFFF; src[5] = 2'b11; req[5] = 64'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            instr  = ins[i];
            ImmSrc = src[i];
            @(negedge clk);
            checks++;
            if (Out !== req[i]) begin
                errors++;
                $display("FAIL directed_%0d: got %h expected %h", i, Out, req[i]);
            end
            checks++;
            if (model(ins[i], src[i]) !== req[i]) begin
                errors++;
                $display("FAIL model_selfcheck_%0d: got %h expected %h", i, model(ins[i], src[i]), req[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp_q;
        logic [63:0] prev;
        // I, S, B, 11 on consecutive edges; each result must land exactly one edge later
        logic [31:0] ins [4];
        logic [1:0]  src [4];
        ins[0] = 32'h12345678; src[0] = 2'b00;
        ins[1] = 32'h87654321; src[1] = 2'b01;
        ins[2] = 32'hABCDEF01; src[2] = 2'b10;
        ins[3] = 32'hFFFFFFFF; src[3] = 2'b11;
        @(negedge clk);
        instr  = ins[0];
        ImmSrc = src[0];
        exp_q  = model(ins[0], src[0]);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (Out !== exp_q) begin
                errors++;
                $display("FAIL b2b_%0d: got %h expected %h", i - 1, Out, exp_q);
            end
            instr  = ins[i];
            ImmSrc = src[i];
            exp_q  = model(ins[i], src[i]);
        end
        @(negedge clk);
        checks++;
        if (Out !== exp_q) begin
            errors++;
            $display("FAIL b2b_3: got %h expected %h", Out, exp_q);
        end
        // mid-sequence reset: load a nonzero value, then clear it between edges
        instr  = 32'hABCDEF01;
        ImmSrc = 2'b10;
        @(negedge clk);
        prev = Out;
        checks++;
        if (prev !== 64'hFFFFFFFFFFFFF2BE) begin
            errors++;
            $display("FAIL b2b_preclear: got %h expected %h", prev, 64'hFFFFFFFFFFFFF2BE);
        end
        instr  = 32'hFFF00093;
        ImmSrc = 2'b00;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (Out !== 64'h0) begin
            errors++;
            $display("FAIL midstream_reset: got %h expected %h", Out, 64'h0);
        end
        @(negedge clk);
        checks++;
        if (Out !== 64'h0) begin
            errors++;
            $display("FAIL midstream_reset_hold: got %h expected %h", Out, 64'h0);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (Out !== 64'hFFFFFFFFFFFFFFFF) begin
            errors++;
            $display("FAIL after_reset_load: got %h expected %h", Out, 64'hFFFFFFFFFFFFFFFF);
        end
    endtask

    task automatic test_random;
        logic [63:0] exp_q;
        logic [31:0] r_ins;
        logic [1:0]  r_src;
        @(negedge clk);
        r_ins  = $urandom;
        r_src  = 2'($urandom_range(0, 3));
        instr  = r_ins;
        ImmSrc = r_src;
        exp_q  = model(r_ins, r_src);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            checks++;
            if (Out !== exp_q) begin
                errors++;
                $display("FAIL random_%0d: got %h expected %h", i, Out, exp_q);
            end
            r_ins  = $urandom;
            r_src  = 2'($urandom_range(0, 3));
            instr  = r_ins;
            ImmSrc = r_src;
            exp_q  = model(r_ins, r_src);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        instr  = 32'h0;
        ImmSrc = 2'b11;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
